// File: rtl/mem_burst_splitter.sv
// Splits one linear burst into single-beat req/gnt memory requests and
// buffers read responses so the non-backpressured rvalid path never drops.
module mem_burst_splitter #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 64,
   parameter int unsigned LenWidth  = 8,
   parameter int unsigned MaxTrans  = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   burst_valid_i,
   output logic                   burst_ready_o,
   input  logic [AddrWidth-1:0]   burst_addr_i,
   input  logic [LenWidth-1:0]    burst_len_i,
   input  logic                   burst_we_i,
   input  logic                   w_valid_i,
   output logic                   w_ready_o,
   input  logic [DataWidth-1:0]   w_data_i,
   input  logic [DataWidth/8-1:0] w_strb_i,
   output logic                   r_valid_o,
   input  logic                   r_ready_i,
   output logic [DataWidth-1:0]   r_data_o,
   output logic                   r_last_o,
   output logic                   b_valid_o,
   input  logic                   b_ready_i,
   output logic                   mem_req_o,
   input  logic                   mem_gnt_i,
   output logic [AddrWidth-1:0]   mem_addr_o,
   output logic [DataWidth-1:0]   mem_wdata_o,
   output logic [DataWidth/8-1:0] mem_strb_o,
   output logic                   mem_we_o,
   input  logic                   mem_rvalid_i,
   input  logic [DataWidth-1:0]   mem_rdata_i
);
   localparam int unsigned BeatBytes = DataWidth / 8;
   localparam int unsigned PtrWidth  = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
   localparam int unsigned CntWidth  = $clog2(MaxTrans + 1);
   localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(BeatBytes - 1);
   localparam logic [AddrWidth-1:0] AddrStep  = AddrWidth'(BeatBytes);

   typedef enum logic [1:0] {IDLE, ISSUE, FINISH} state_e;

   state_e                 state;
   logic                   burst_ready_q, b_valid_q, we_q;
   logic [AddrWidth-1:0]   beat_addr;
   logic [LenWidth-1:0]    len_q, issued, popped;
   logic [LenWidth:0]      wresp, wresp_next, len_plus1;
   logic [CntWidth-1:0]    outstanding, fifo_cnt;
   logic [PtrWidth-1:0]    wr_ptr, rd_ptr;
   logic [DataWidth-1:0]   fifo_mem [MaxTrans];
   logic                   credit_ok, grant, rd_push, wr_rvalid, pop, retire;
   logic                   fifo_store, fifo_take;

   assign credit_ok = outstanding < CntWidth'(MaxTrans);

   always_comb begin
      mem_req_o   = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_strb_o  = '0;
      mem_we_o    = 1'b0;
      if (state == ISSUE) begin
         mem_addr_o = beat_addr;
         mem_we_o   = we_q;
         if (we_q) begin
            mem_req_o   = credit_ok & w_valid_i;
            mem_wdata_o = w_data_i;
            mem_strb_o  = w_strb_i;
         end else begin
            mem_req_o   = credit_ok;
            mem_strb_o  = '1;
         end
      end
   end

   assign grant     = mem_req_o & mem_gnt_i;
   assign w_ready_o = grant & we_q;
   assign rd_push   = mem_rvalid_i & ~we_q;
   assign wr_rvalid = mem_rvalid_i & we_q;

   // Fall-through: an empty FIFO forwards the memory response in the same cycle.
   assign r_valid_o  = (fifo_cnt != '0) | rd_push;
   assign r_data_o   = (fifo_cnt != '0) ? fifo_mem[rd_ptr] : mem_rdata_i;
   assign r_last_o   = r_valid_o & (popped == len_q);
   assign pop        = r_valid_o & r_ready_i;
   assign fifo_take  = pop & (fifo_cnt != '0);
   assign fifo_store = rd_push & ~(pop & (fifo_cnt == '0));
   assign retire     = pop | wr_rvalid;

   assign wresp_next = wresp + {{LenWidth{1'b0}}, wr_rvalid};
   assign len_plus1  = {1'b0, len_q} + {{LenWidth{1'b0}}, 1'b1};

   assign burst_ready_o = burst_ready_q;
   assign b_valid_o     = b_valid_q;

   always_ff @(posedge clk_i) begin
      if (fifo_store) fifo_mem[wr_ptr] <= mem_rdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         burst_ready_q <= 1'b1;
         b_valid_q     <= 1'b0;
         we_q          <= 1'b0;
         beat_addr     <= '0;
         len_q         <= '0;
         issued        <= '0;
         popped        <= '0;
         wresp         <= '0;
         outstanding   <= '0;
         fifo_cnt      <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
      end else begin
         unique case ({grant, retire})
            2'b10:   outstanding <= outstanding + CntWidth'(1);
            2'b01:   outstanding <= outstanding - CntWidth'(1);
            default: ;
         endcase
         unique case ({fifo_store, fifo_take})
            2'b10:   fifo_cnt <= fifo_cnt + CntWidth'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CntWidth'(1);
            default: ;
         endcase
         if (fifo_store) wr_ptr <= (wr_ptr == PtrWidth'(MaxTrans - 1)) ? '0 : wr_ptr + PtrWidth'(1);
         if (fifo_take)  rd_ptr <= (rd_ptr == PtrWidth'(MaxTrans - 1)) ? '0 : rd_ptr + PtrWidth'(1);
         if (pop)        popped <= popped + LenWidth'(1);
         wresp <= wresp_next;

         unique case (state)
            IDLE: begin
               if (burst_valid_i) begin
                  beat_addr     <= burst_addr_i & AlignMask;
                  len_q         <= burst_len_i;
                  we_q          <= burst_we_i;
                  issued        <= '0;
                  popped        <= '0;
                  wresp         <= '0;
                  burst_ready_q <= 1'b0;
                  state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (grant) begin
                  beat_addr <= beat_addr + AddrStep;
                  issued    <= issued + LenWidth'(1);
                  if (issued == len_q) state <= FINISH;
               end
            end
            FINISH: begin
               if (!we_q) begin
                  if (pop && r_last_o) begin
                     state         <= IDLE;
                     burst_ready_q <= 1'b1;
                  end
               end else if (b_valid_q && b_ready_i) begin
                  b_valid_q     <= 1'b0;
                  state         <= IDLE;
                  burst_ready_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (state != IDLE && we_q && !b_valid_q && wresp_next == len_plus1)
            b_valid_q <= 1'b1;
      end
   end

   rvalid_needs_outstanding: assert property (
      @(posedge clk_i) disable iff (rst_i) !(mem_rvalid_i && outstanding == '0));

endmodule

// File: tb/tb_mem_burst_splitter.sv
// Bench for mem_burst_splitter: memory responder with latency/grant jitter,
// vector table, hand-written corner sequences and randomized bursts.
module tb_mem_burst_splitter;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        burst_valid_i, burst_ready_o, burst_we_i;
   logic [31:0] burst_addr_i;
   logic [7:0]  burst_len_i;
   logic        w_valid_i, w_ready_o;
   logic [63:0] w_data_i;
   logic [7:0]  w_strb_i;
   logic        r_valid_o, r_ready_i, r_last_o;
   logic [63:0] r_data_o;
   logic        b_valid_o, b_ready_i;
   logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
   logic [31:0] mem_addr_o;
   logic [63:0] mem_wdata_o, mem_rdata_i;
   logic [7:0]  mem_strb_o;

   mem_burst_splitter #(.AddrWidth(32), .DataWidth(64), .LenWidth(8), .MaxTrans(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .burst_valid_i(burst_valid_i), .burst_ready_o(burst_ready_o),
      .burst_addr_i(burst_addr_i), .burst_len_i(burst_len_i), .burst_we_i(burst_we_i),
      .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
      .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o), .r_last_o(r_last_o),
      .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_we_o(mem_we_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i));

   always #5 clk_i = ~clk_i;

   typedef struct { logic [31:0] addr; logic we; logic [63:0] wdata; logic [7:0] strb; int t; } req_t;
   typedef struct { logic [63:0] data; logic last; int t; } rbeat_t;
   typedef struct { int due; logic [63:0] data; } pend_t;
   typedef struct {
      logic [31:0] addr; int len; logic we;
      int gnt, wv, rr, br, lat;
      int exp_beats; logic [31:0] exp_first, exp_last;
   } vec_t;

   req_t        req_log[$];
   rbeat_t      r_log[$];
   pend_t       pend[$];
   logic [63:0] wq_data[$];
   logic [7:0]  wq_strb[$];
   vec_t        vecs[6];
   int cyc = 0, wi = 0, b_cnt = 0, b_rise_t = -1, last_rv_t = -1;
   int lat = 1, gnt_pct = 100, w_pct = 100, r_pct = 100, b_pct = 100;
   bit fixed_rdata = 1'b0;
   int n_checks = 0, n_fail = 0;
   logic stall_prev = 1'b0, b_prev = 1'b0, w_acc;
   req_t stall_req;

   function automatic logic [63:0] rdata_of(input logic [31:0] a);
      return fixed_rdata ? 64'hA5A5 : {a ^ 32'h5A5A_1234, ~a};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory: grants with probability gnt_pct, answers each grant after lat cycles.
   initial begin
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            pend.delete();
            mem_rvalid_i = 1'b0;
         end else if (mem_req_o && mem_gnt_i)
            pend.push_back('{due: cyc + lat, data: mem_we_o ? 64'h0 : rdata_of(mem_addr_o)});
         @(posedge clk_i); #1;
         cyc++;
         mem_rvalid_i = 1'b0;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = pend[0].data;
            void'(pend.pop_front());
         end
         mem_gnt_i = ($urandom_range(99) < gnt_pct);
      end
   end

   // Upstream write-data source and downstream ready generators.
   initial begin
      w_valid_i = 1'b0; w_data_i = '0; w_strb_i = '0; r_ready_i = 1'b0; b_ready_i = 1'b0;
      forever begin
         @(negedge clk_i);
         w_acc = w_valid_i && w_ready_o;
         @(posedge clk_i); #1;
         if (w_acc) wi++;
         if (rst_i) w_valid_i = 1'b0;
         else if (!w_valid_i || w_acc) begin
            if (wi < wq_data.size() && $urandom_range(99) < w_pct) begin
               w_valid_i = 1'b1; w_data_i = wq_data[wi]; w_strb_i = wq_strb[wi];
            end else w_valid_i = 1'b0;
         end
         r_ready_i = ($urandom_range(99) < r_pct);
         b_ready_i = ($urandom_range(99) < b_pct);
      end
   end

   // Monitor: logs handshakes and checks request stability under stall.
   initial begin
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            stall_prev = 1'b0; b_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               check("req_held", mem_req_o, 1);
               check("addr_held", mem_addr_o, stall_req.addr);
               check("we_held", mem_we_o, stall_req.we);
               check("wdata_held", mem_wdata_o, stall_req.wdata);
               check("strb_held", mem_strb_o, stall_req.strb);
            end
            stall_req  = '{mem_addr_o, mem_we_o, mem_wdata_o, mem_strb_o, cyc};
            stall_prev = mem_req_o && !mem_gnt_i;
            if (mem_req_o && mem_gnt_i) req_log.push_back(stall_req);
            if (r_valid_o && r_ready_i) r_log.push_back('{r_data_o, r_last_o, cyc});
            if (mem_rvalid_i) last_rv_t = cyc;
            if (b_valid_o && !b_prev) b_rise_t = cyc;
            b_prev = b_valid_o;
            if (b_valid_o && b_ready_i) b_cnt++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk_i); @(posedge clk_i); #1;
   endtask

   task automatic prep(input int len, input logic we);
      req_log.delete(); r_log.delete(); wq_data.delete(); wq_strb.delete();
      b_cnt = 0; wi = 0;
      if (we) for (int i = 0; i <= len; i++) begin
         wq_data.push_back({$urandom, $urandom});
         wq_strb.push_back((i == 1) ? 8'h00 : 8'($urandom));
      end
   endtask

   task automatic start_burst(input logic [31:0] a, input int len, input logic we, output int t_acc);
      burst_valid_i = 1'b1; burst_addr_i = a; burst_len_i = 8'(len); burst_we_i = we;
      t_acc = -1;
      for (int i = 0; i < 300 && t_acc < 0; i++) begin
         @(negedge clk_i);
         if (burst_ready_o) t_acc = cyc;
         @(posedge clk_i); #1;
      end
      burst_valid_i = 1'b0;
      check("burst_accepted", t_acc >= 0, 1);
   endtask

   task automatic wait_done(input int len, input logic we);
      bit done = 1'b0;
      for (int i = 0; i < 3000 && !done; i++) begin
         step();
         done = we ? (b_cnt > 0) : (r_log.size() == len + 1);
      end
      check("burst_done_in_time", done, 1);
   endtask

   // Reference: beat i goes to (base & ~7) + 8*i mod 2^32; reads return rdata_of(addr).
   task automatic check_model(input logic [31:0] a, input int len, input logic we);
      logic [31:0] base = a & ~32'h7;
      logic [31:0] ea;
      check("beat_count", req_log.size(), len + 1);
      for (int i = 0; i <= len && i < req_log.size(); i++) begin
         ea = base + 32'(i * 8);
         check($sformatf("addr[%0d]", i), req_log[i].addr, ea);
         check($sformatf("we[%0d]", i), req_log[i].we, we);
         check($sformatf("wdata[%0d]", i), req_log[i].wdata, we ? wq_data[i] : 64'h0);
         check($sformatf("strb[%0d]", i), req_log[i].strb, we ? wq_strb[i] : 8'hFF);
      end
      if (!we) begin
         check("r_beats", r_log.size(), len + 1);
         for (int i = 0; i <= len && i < r_log.size(); i++) begin
            ea = base + 32'(i * 8);
            check($sformatf("rdata[%0d]", i), r_log[i].data, rdata_of(ea));
            check($sformatf("rlast[%0d]", i), r_log[i].last, i == len);
         end
      end else begin
         check("b_handshakes", b_cnt, 1);
         check("no_r_on_write", r_log.size(), 0);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_burst_ready"}, burst_ready_o, 1);
      check({tag, "_mem_req"}, mem_req_o, 0);
      check({tag, "_w_ready"}, w_ready_o, 0);
      check({tag, "_r_valid"}, r_valid_o, 0);
      check({tag, "_r_last"}, r_last_o, 0);
      check({tag, "_b_valid"}, b_valid_o, 0);
      check({tag, "_mem_addr"}, mem_addr_o, 0);
      check({tag, "_mem_wdata"}, mem_wdata_o, 0);
      check({tag, "_mem_strb"}, mem_strb_o, 0);
      check({tag, "_mem_we"}, mem_we_o, 0);
   endtask

   initial begin
      int t, t2, p;
      bit seen;
      logic [31:0] ra;
      int rl;
      logic rw;
      rst_i = 1'b1; burst_valid_i = 1'b0; burst_addr_i = '0; burst_len_i = '0; burst_we_i = 1'b0;
      //           addr          len we  gnt  wv   rr   br  lat beats first         last
      vecs[0] = '{32'h0000_1003, 0, 0, 100, 100, 100, 100, 1, 1, 32'h0000_1000, 32'h0000_1000};
      vecs[1] = '{32'hFFFF_FFF8, 1, 0, 100, 100, 100, 100, 1, 2, 32'hFFFF_FFF8, 32'h0000_0000};
      vecs[2] = '{32'h0000_0010, 3, 1,  60,  50, 100,  70, 2, 4, 32'h0000_0010, 32'h0000_0028};
      vecs[3] = '{32'h0000_2007, 7, 0,  70, 100,  60, 100, 4, 8, 32'h0000_2000, 32'h0000_2038};
      vecs[4] = '{32'hFFFF_FFF4, 3, 1,  80,  70, 100,  50, 3, 4, 32'hFFFF_FFF0, 32'h0000_0008};
      vecs[5] = '{32'h0000_0100,15, 0, 100, 100, 100, 100, 1,16, 32'h0000_0100, 32'h0000_0178};

      repeat (3) @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check_reset("reset");
      @(posedge clk_i); #1;

      for (int v = 0; v < 6; v++) begin
         gnt_pct = vecs[v].gnt; w_pct = vecs[v].wv; r_pct = vecs[v].rr;
         b_pct = vecs[v].br; lat = vecs[v].lat;
         prep(vecs[v].len, vecs[v].we);
         start_burst(vecs[v].addr, vecs[v].len, vecs[v].we, t);
         wait_done(vecs[v].len, vecs[v].we);
         check($sformatf("vec%0d_beats", v), req_log.size(), vecs[v].exp_beats);
         if (req_log.size() > 0) begin
            check($sformatf("vec%0d_first", v), req_log[0].addr, vecs[v].exp_first);
            check($sformatf("vec%0d_last", v), req_log[req_log.size()-1].addr, vecs[v].exp_last);
         end
         check_model(vecs[v].addr, vecs[v].len, vecs[v].we);
      end

      // Single-beat read latency
      fixed_rdata = 1'b1; lat = 1; gnt_pct = 100; r_pct = 100; b_pct = 100; w_pct = 100;
      prep(0, 0);
      start_burst(32'h1003, 0, 0, t);
      wait_done(0, 0);
      check_model(32'h1003, 0, 0);
      if (req_log.size() > 0) check("single_req_cycle", req_log[0].t, t + 1);
      if (r_log.size() > 0) begin
         check("single_rvalid_cycle", r_log[0].t, t + 2);
         check("single_rdata", r_log[0].data, 64'hA5A5);
      end
      @(negedge clk_i);
      check("single_back_idle", burst_ready_o, 1);
      check("single_r_valid_low", r_valid_o, 0);
      @(posedge clk_i); #1;
      fixed_rdata = 1'b0;

      // Credit limit with stalled read channel
      lat = 2; r_pct = 0;
      prep(7, 0);
      start_burst(32'h0, 7, 0, t);
      repeat (12) step();
      check("credit_grants", req_log.size(), 4);
      @(negedge clk_i);
      check("credit_req_low", mem_req_o, 0);
      @(posedge clk_i); #1;
      r_pct = 100;
      wait_done(7, 0);
      check_model(32'h0, 7, 0);

      // Write burst with b_ready held low
      lat = 2; gnt_pct = 50; w_pct = 50; b_pct = 0;
      prep(3, 1);
      start_burst(32'h400, 3, 1, t);
      seen = 1'b0;
      for (int i = 0; i < 500 && !seen; i++) begin
         @(negedge clk_i);
         seen = b_valid_o;
         @(posedge clk_i); #1;
      end
      check("b_valid_seen", seen, 1);
      check("b_after_last_rvalid", b_rise_t, last_rv_t + 1);
      check("wresp_beats_before_b", req_log.size(), 4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check("b_valid_holds", b_valid_o, 1);
         @(posedge clk_i); #1;
      end
      b_pct = 100;
      wait_done(3, 1);
      check_model(32'h400, 3, 1);
      @(negedge clk_i);
      check("b_valid_cleared", b_valid_o, 0);
      @(posedge clk_i); #1;

      // Full throughput and back-to-back bursts
      lat = 1; gnt_pct = 100; w_pct = 100; r_pct = 100;
      prep(3, 0);
      start_burst(32'h3000, 3, 0, t);
      wait_done(3, 0);
      check_model(32'h3000, 3, 0);
      p = -100;
      if (r_log.size() == 4) begin
         check("b2b_first_pop", r_log[0].t, t + 2);
         for (int i = 1; i < 4; i++) begin
            check($sformatf("b2b_pop_gap[%0d]", i), r_log[i].t, r_log[0].t + i);
            check($sformatf("b2b_req_gap[%0d]", i), req_log[i].t, req_log[0].t + i);
         end
         p = r_log[3].t;
      end
      prep(1, 0);
      start_burst(32'h3100, 1, 0, t2);
      check("b2b_next_accept", t2, p + 1);
      wait_done(1, 0);
      check_model(32'h3100, 1, 0);

      // Reset in the middle of a read burst
      lat = 3; r_pct = 0;
      prep(5, 0);
      start_burst(32'h5000, 5, 0, t);
      for (int i = 0; i < 100 && req_log.size() < 2; i++) step();
      check("rst_two_grants", req_log.size(), 2);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check_reset("midrst");
      @(posedge clk_i); #1;
      lat = 1; r_pct = 100;
      prep(0, 0);
      start_burst(32'h6008, 0, 0, t);
      wait_done(0, 0);
      check_model(32'h6008, 0, 0);

      // Randomized bursts
      for (int n = 0; n < 20; n++) begin
         ra = $urandom;
         if ($urandom_range(3) == 0) ra = 32'hFFFF_FF00 | 32'($urandom_range(255));
         rl = $urandom_range(12);
         rw = 1'($urandom_range(1));
         gnt_pct = $urandom_range(30, 100); w_pct = $urandom_range(30, 100);
         r_pct = $urandom_range(30, 100); b_pct = $urandom_range(30, 100);
         lat = $urandom_range(1, 4);
         prep(rl, rw);
         start_burst(ra, rl, rw, t);
         wait_done(rl, rw);
         check_model(ra, rl, rw);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_burst_splitter.md
# mem_burst_splitter

Upstream feeder for the bank splitter: accepts one linear burst (base address, beat count, direction), issues it as single-beat `req/gnt` memory requests at full data width, and collects the `rvalid` responses. Read data is buffered so the downstream `rvalid` channel, which has no back-pressure, can never be dropped. Write completion is reported once per burst. It sits between a DMA or AXI-style front end and the bank-splitting stage.

## Interface
- `AddrWidth`, 32, byte address width.
- `DataWidth`, 64, beat width; power of two, at least 8.
- `LenWidth`, 8, width of the burst length field; beats = len+1.
- `MaxTrans`, 4, maximum outstanding beats; also the read-buffer depth; at least 1.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock; synchronous, active-high.
- `burst_valid_i` / `burst_ready_o`  in/out  1  burst command handshake.
- `burst_addr_i`  in  AddrWidth  burst base byte address.
- `burst_len_i`  in  LenWidth  beats minus 1.
- `burst_we_i`  in  1  1 = write burst.
- `w_valid_i` / `w_ready_o`  in/out  1  write-data beat handshake.
- `w_data_i`  in  DataWidth  write data.
- `w_strb_i`  in  DataWidth/8  write byte strobes.
- `r_valid_o` / `r_ready_i`  out/in  1  read-data beat handshake.
- `r_data_o`  out  DataWidth  read data.
- `r_last_o`  out  1  marks the final beat of the burst.
- `b_valid_o` / `b_ready_i`  out/in  1  write-burst completion handshake.
- `mem_req_o` / `mem_gnt_i`  out/in  1  memory request handshake.
- `mem_addr_o`  out  AddrWidth  memory request address.
- `mem_wdata_o`  out  DataWidth  memory write data.
- `mem_strb_o`  out  DataWidth/8  memory write strobes.
- `mem_we_o`  out  1  memory write enable.
- `mem_rvalid_i`  in  1  memory response valid; one per granted beat, reads and writes.
- `mem_rdata_i`  in  DataWidth  memory read data.

## Operation
FSM has three states: IDLE, ISSUE, FINISH.

IDLE
- `burst_ready_o` = 1.
- On `burst_valid_i & burst_ready_o`, register the following and go to ISSUE:
  - base address aligned down to DataWidth/8 bytes,
  - len,
  - we,
  - beat counter `issued` = 0.

ISSUE
- Beat address = `aligned_base + issued*(DataWidth/8)`, computed modulo 2^AddrWidth; the address wraps silently.
- `credit_ok` = `outstanding < MaxTrans`.
- Read burst: `mem_req_o = credit_ok`; `mem_strb_o` = all ones; `mem_wdata_o` = 0.
- Write burst:
  - `mem_req_o = credit_ok & w_valid_i`.
  - `mem_wdata_o` = `w_data_i`, `mem_strb_o` = `w_strb_i`.
  - `w_ready_o = mem_req_o & mem_gnt_i`.
- `mem_we_o` = the registered we.
- A grant increments `issued` and `outstanding`.
- The grant for beat len moves the FSM to FINISH.
- Zero-strobe write beats are still issued; they are not suppressed here.

Responses
- Read: each `mem_rvalid_i` pushes `mem_rdata_i` into a fall-through FIFO of depth MaxTrans.
  - FIFO non-empty drives `r_valid_o`.
  - A pop (`r_valid_o & r_ready_i`) decrements `outstanding`.
  - A push and a pop in the same cycle are legal; occupancy stays unchanged.
- Write: each `mem_rvalid_i` decrements `outstanding` and increments `wresp`.
- `outstanding` counts beats granted but not yet retired; for reads it includes beats still held in the FIFO. The FIFO therefore never overflows.
- Read beats are counted as they are popped. `r_last_o` = `r_valid_o` when the popped-beat count equals len.

FINISH
- Read: the pop of the last beat returns the FSM to IDLE.
- Write: `b_valid_o` = 1 once `wresp == len+1`; the `b_valid_o & b_ready_i` handshake returns the FSM to IDLE.
- No new burst is accepted until return to IDLE; bursts never overlap.

Errors and reset
- `mem_rvalid_i` arriving with `outstanding == 0` is a protocol violation and must be asserted against.
- The memory side shares `rst_i`.
- `rst_i` asserted mid-burst aborts the burst, clears the FIFO, clears all counters and returns the FSM to IDLE.

## Timing
- Reset values:
  - `burst_ready_o` = 1 (FSM in IDLE).
  - All other outputs = 0: `mem_req_o`, `w_ready_o`, `r_valid_o`, `r_last_o`, `b_valid_o`, `mem_addr_o`, `mem_wdata_o`, `mem_strb_o`, `mem_we_o`.
- Burst handshake in cycle N puts the first `mem_req_o` in N+1.
- Peak throughput is 1 beat per cycle.
- With memory latency L cycles from grant to `rvalid` and `r_ready_i` held high:
  - `r_valid_o` for beat k appears in cycle N+1+k+L, same cycle as `mem_rvalid_i` via fall-through.
  - Full throughput requires MaxTrans ≥ L+1.
- Write completion: `b_valid_o` rises the cycle after the last write `rvalid`. It is registered.
- `mem_req_o` may only drop after a grant. `mem_addr_o`, `mem_we_o`, `mem_wdata_o` and `mem_strb_o` stay stable while `mem_req_o & !mem_gnt_i`.
- Upstream must keep `w_valid_i` and `w_data_i` stable until `w_ready_o`.
- No combinational path from `mem_rvalid_i` to `mem_req_o`.

## Test plan
- **Single-beat read:** reset, burst addr=0x1003, len=0, we=0; memory gnt=1, L=1, returns 0xA5A5 -> exactly one request, at addr 0x1000. Then `r_valid_o` with `r_last_o`=1 and data 0xA5A5, then back to IDLE.
- **Read credit limit:** len=7, MaxTrans=4, `r_ready_i`=0 -> exactly 4 grants, then `mem_req_o` stays low. Raising `r_ready_i` resumes issue. All 8 beats delivered in order, addresses 0x0 to 0x38, `r_last_o` only on beat 7.
- **Write burst with stalls:** len=3, `w_valid_i` toggling, `mem_gnt_i` random -> 4 requests with data and strobes matching the accepted beats. `b_valid_o` only after 4 `rvalid`; it holds while `b_ready_i`=0 and clears on the handshake.
- **Address wrap:** AddrWidth=32, addr=0xFFFF_FFF8, len=1 -> beat addresses 0xFFFF_FFF8 then 0x0000_0000.
- **Simultaneous push/pop and back-to-back bursts:** L=1 with continuous `r_ready_i` -> 1 beat/cycle and FIFO occupancy ≤ 1. The next burst is accepted the cycle after the last pop.
- **Reset mid-burst:** assert `rst_i` after 2 of 6 grants -> the cycle after reset all outputs hold their reset values and `burst_ready_o`=1. A fresh len=0 read then completes normally.
